// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply/divide unit.
// Shift-add multiply and restoring divide, one iteration per cycle over
// 32 cycles. The 32-bit adder sits outside the block and is shared through
// the add_* ports.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] add_op1,
  output logic [31:0] add_op2,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;       // H for multiply, R for divide
  logic [31:0] lo_q, lo_d;       // L for multiply, Q for divide
  logic [31:0] dv_q, dv_d;       // rs1 for multiply, divisor D for divide
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [31:0] rs_s;             // divide: remainder shifted left with next quotient bit

  // Next-state, datapath iteration and shared-adder operand selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dv_d     = dv_q;
    result_d = result_q;
    add_op1  = 32'd0;
    add_op2  = 32'd0;
    add_cin  = 1'b0;
    rs_s     = {hi_q[30:0], lo_q[31]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          cnt_d   = 5'd0;
          hi_d    = 32'd0;
          // Multiply keeps the multiplier in L; divide keeps the dividend in Q.
          lo_d    = op[1] ? rs1 : rs2;
          dv_d    = op[1] ? rs2 : rs1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (!op_q[1]) begin
          // Shift-add: add rs1 into H when the current multiplier bit is set.
          add_op1 = hi_q;
          add_op2 = dv_q;
          add_cin = 1'b0;
          if (lo_q[0]) begin
            hi_d = {add_carry, add_sum[31:1]};
            lo_d = {add_sum[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end else begin
          // Restoring divide: trial subtract Rs - D as Rs + ~D + 1.
          add_op1 = rs_s;
          add_op2 = ~dv_q;
          add_cin = 1'b1;
          // R[31] set means Rs is a 33-bit value, always >= D.
          if (hi_q[31] | add_carry) begin
            hi_d = add_sum;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = rs_s;
            lo_d = {lo_q[30:0], 1'b0};
          end
        end
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          // op[0] picks the upper word: MULHU -> H, REMU -> R.
          result_d = op_q[0] ? hi_d : lo_d;
        end else begin
          state_d  = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dv_q     <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dv_q     <= dv_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: plain-arithmetic reference model,
// a per-cycle compare process, and directed vectors with literal results.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result, add_op1, add_op2, add_sum;
  logic        add_cin, add_carry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External shared adder.
  assign {add_carry, add_sum} = {1'b0, add_op1} + {1'b0, add_op2} + {32'd0, add_cin};

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .add_op1(add_op1), .add_op2(add_op2), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Reference model: m_cnt = 0 idle, 1..32 run cycles, 33 done cycle.
  int          m_cnt = 0;
  logic [1:0]  m_op  = 2'd0;
  logic [31:0] m_a   = 32'd0;
  logic [31:0] m_b   = 32'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_res = 32'd0;
    end else if (m_cnt == 0) begin
      if (start === 1'b1) begin
        m_cnt = 1;
        m_op  = op;
        m_a   = rs1;
        m_b   = rs2;
      end
    end else if (m_cnt == 33) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 33) m_res = ref_calc(m_op, m_a, m_b);
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
    chk("done", {31'd0, done}, {31'd0, (m_cnt == 33)});
    chk("result", result, m_res);
    if (m_cnt == 0 || m_cnt == 33) begin
      chk("add_op1_idle", add_op1, 32'd0);
      chk("add_op2_idle", add_op2, 32'd0);
      chk("add_cin_idle", {31'd0, add_cin}, 32'd0);
    end else begin
      chk("add_op2_run", add_op2, m_op[1] ? ~m_b : m_a);
      chk("add_cin_run", {31'd0, add_cin}, {31'd0, m_op[1]});
    end
  end

  // One operation: accept, scramble inputs after acceptance, wait for done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0; op = o ^ 2'b11; rs1 = $urandom; rs2 = $urandom;
      end
    end while (done !== 1'b1 && lat < 60);
    chk({name, "_latency"}, lat, 32'd33);
    chk(name, result, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs1 = 32'd0; rs2 = 32'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_add_op1", add_op1, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op("mul_7x6",     2'd0, 32'd7, 32'd6, 32'h0000_002A);
    run_op("mulhu_7x6",   2'd1, 32'd7, 32'd6, 32'h0000_0000);
    run_op("mul_ones",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mulhu_ones",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("divu_100_7",  2'd2, 32'd100, 32'd7, 32'h0000_000E);
    run_op("remu_100_7",  2'd3, 32'd100, 32'd7, 32'h0000_0002);
    run_op("divu_msb_1",  2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000);
    run_op("remu_msb_1",  2'd3, 32'h8000_0000, 32'd1, 32'h0000_0000);
    run_op("divu_by0",    2'd2, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0",    2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234);

    // start held high through RUN and DONE with new operands.
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs1 = 32'd7; rs2 = 32'd6;
    @(negedge clk);
    op = 2'd2; rs1 = 32'd100; rs2 = 32'd7;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_latency", n, 32'd33);
    chk("held_first_result", result, 32'h0000_002A);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) start = 1'b0;
    end while (done !== 1'b1 && n < 60);
    chk("held_second_latency", n, 32'd34);
    chk("held_second_result", result, 32'h0000_000E);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs1 = 32'd7; rs2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_result", result, 32'd0);
    chk("midrun_rst_add_op2", add_op2, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("mul_after_rst", 2'd0, 32'd7, 32'd6, 32'h0000_002A);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have the following ports, with clock and reset first:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MUL (low 32 bits), 01 MULHU (high 32 bits), 10 DIVU, 11 REMU; all unsigned.
REQ-006 rs1  input  32  multiplicand or dividend.
REQ-007 rs2  input  32  multiplier or divisor.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  32  final value; held until next accepted start.
REQ-011 add_op1  output  32  shared 32-bit ripple adder operand A.
REQ-012 add_op2  output  32  shared adder operand B.
REQ-013 add_cin  output  1  shared adder carry-in.
REQ-014 add_sum  input  32  adder sum, combinational from add_op1/add_op2/add_cin.
REQ-015 add_carry  input  1  adder carry-out (bit 32).

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE: start=1 at an edge SHALL latch op, rs1 and rs2, clear the 5-bit iteration counter, and go to RUN.
REQ-018 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-019 RUN SHALL last exactly 32 cycles, one adder use per cycle, and then go to DONE; DONE SHALL last 1 cycle and then go to IDLE.
REQ-020 Latency: start sampled at edge k -> done=1 in the cycle following edge k+32 -> IDLE at edge k+33.
REQ-021 MUL/MULHU SHALL use a 64-bit shift-add register {H,L}, with H=0 and L=rs2 at start.
REQ-022 MUL/MULHU per cycle: add_op1=H, add_op2=rs1 (latched), add_cin=0.
REQ-023 MUL/MULHU per cycle: if L[0]=1, {H,L} <= {add_carry, add_sum, L} >> 1; else {H,L} <= {1'b0, H, L} >> 1.
REQ-024 At DONE, result SHALL be L for MUL and H for MULHU.
REQ-025 DIVU/REMU SHALL use restoring division with remainder R=0 and quotient Q=rs1 at start, and divisor D=rs2.
REQ-026 DIVU/REMU per cycle: Rs={R[30:0],Q[31]}; add_op1=Rs, add_op2=~D, add_cin=1.
REQ-027 DIVU/REMU per cycle: if R[31]|add_carry, then R<=add_sum and Q<={Q[30:0],1}; else R<=Rs and Q<={Q[30:0],0}.
REQ-028 At DONE, result SHALL be Q for DIVU and R for REMU.
REQ-029 Divide by zero SHALL need no special path and SHALL yield DIVU=0xFFFFFFFF and REMU=rs1.
REQ-030 In IDLE and DONE, add_op1, add_op2 and add_cin SHALL be 0.
REQ-031 done SHALL be registered and high only in the DONE cycle; result SHALL update only on the RUN->DONE edge.
REQ-032 rs1, rs2 and op changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, result=0, all datapath registers and counter=0, and adder outputs=0.
REQ-034 Reset mid-RUN or mid-DONE SHALL abort the operation with no done pulse; the first start after rst_n=1 SHALL complete normally.

Verification
REQ-035 MUL rs1=7, rs2=6 -> done exactly 33 cycles after start edge, result=0x0000002A; MULHU same operands -> 0x00000000.
REQ-036 rs1=rs2=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE; add_carry path exercised.
REQ-037 DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 0x80000000/1 -> 0x80000000, REMU -> 0.
REQ-038 Divide by zero, rs1=0x00001234, rs2=0: DIVU -> 0xFFFFFFFF; REMU -> 0x00001234.
REQ-039 start held high through RUN and DONE with new operands -> ignored; first op result unchanged; next op accepted on the first IDLE edge.
REQ-040 rst_n pulsed low at RUN cycle 10 -> busy=0, done=0 and result=0 asynchronously; no done afterward; rerun MUL 7*6 -> 0x2A.
